// File: rtl/upower_mem_pkg.sv
// Shared definitions for the uPower data-memory responder: FSM state
// encoding, default geometry/latency, and a counter-width helper.
package upower_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_N     = 32;
  localparam int DEF_DEPTH = 128;
  localparam int DEF_LAT   = 2;

  // Width of a down-counter that must hold the value lat (at least 1 bit).
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// DEPTH x N word storage with a synchronous byte-enabled write port and a
// combinational read port. Contents survive reset.
module mem_array #(
  parameter int N     = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [N-1:0]     wdata_i,
  input  logic [N/8-1:0]   be_i,
  output logic [N-1:0]     rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  // Byte-lane write: only lanes with their enable set are replaced.
  // NOTE: storage has no reset branch; clearing a RAM on reset is not
  // possible in a real macro and would turn it into a huge flop array.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < N/8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Timed data-memory slave: accepts one load/store at a time, waits LAT
// cycles, performs the access on the edge that enters RESP and holds the
// response until the requester takes it.
module data_mem_responder
  import upower_mem_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [N-1:0]     req_addr,
  input  logic [N-1:0]     req_wdata,
  input  logic [N/8-1:0]   req_be,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_rdata,
  output logic             resp_err
);

  localparam int BE_W  = N / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(LAT);

  localparam logic [N-1:0]     DEPTH_N = N'(DEPTH);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [N-1:0]      addr_q;
  logic [N-1:0]      wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [N-1:0]      resp_rdata_q;
  logic              resp_err_q;

  logic              accept;
  logic              enter_resp;
  logic              acc_write;
  logic [N-1:0]      acc_addr;
  logic [N-1:0]      acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_in_range;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [N-1:0]      mem_rdata;
  logic [N-1:0]      resp_rdata_d;
  logic              resp_err_d;

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign accept     = req_valid && req_ready;

  // Pick the access operands: live request when LAT=0 enters RESP straight
  // from IDLE, otherwise the latched request.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    acc_write  = write_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_be     = be_q;
    enter_resp = 1'b0;
    if (state_q == ST_IDLE) begin
      acc_write  = req_write;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
      acc_be     = req_be;
      enter_resp = accept && (LAT == 0);
    end else if (state_q == ST_WAIT) begin
      enter_resp = (cnt_q == ONE_C);
    end
  end

  // Range check on the full address and the response that access produces.
  always_comb begin
    acc_in_range = (acc_addr < DEPTH_N);
    mem_we       = enter_resp && acc_write && acc_in_range;
    mem_addr     = acc_addr[AW-1:0];
    resp_err_d   = !acc_in_range;
    resp_rdata_d = '0;
    if (acc_in_range && !acc_write) resp_rdata_d = mem_rdata;
  end

  mem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (mem_rdata)
  );

  // Request FSM, wait counter, request latches and response registers.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (enter_resp) begin
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= resp_err_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt_q   <= LAT_C;
            state_q <= (LAT == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == ONE_C) begin
            cnt_q   <= '0;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - ONE_C;
          end
        end
        ST_RESP: begin
          if (resp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LAT=2 and a LAT=0 instance driven with
// directed and random traffic, compared every cycle against a
// transaction-level model (word array plus one pending-request record).
module tb_data_mem_responder;

  localparam int N     = 32;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        resp_ready[2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic        resp_err  [2];
  logic [31:0] resp_rdata[2];

  int     vectors     = 0;
  int     miscompares = 0;
  longint cyc         = 0;

  data_mem_responder #(.N(N), .DEPTH(DEPTH), .LAT(2)) dut_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.N(N), .DEPTH(DEPTH), .LAT(0)) dut_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [2][DEPTH];
  bit          busy     [2] = '{0, 0};
  longint      resp_at  [2];
  bit          committed[2];
  bit          out_known[2] = '{0, 0};
  logic        p_write  [2];
  logic [31:0] p_addr   [2];
  logic [31:0] p_wdata  [2];
  logic [3:0]  p_be     [2];
  logic [31:0] k_rdata  [2];
  logic        k_err    [2];

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        check($sformatf("d%0d_rst_req_ready", d), {31'b0, req_ready[d]}, 32'd0);
        check($sformatf("d%0d_rst_resp_valid", d), {31'b0, resp_valid[d]}, 32'd0);
        check($sformatf("d%0d_rst_rdata", d), resp_rdata[d], 32'd0);
        check($sformatf("d%0d_rst_err", d), {31'b0, resp_err[d]}, 32'd0);
        busy[d] = 0; out_known[d] = 1; k_rdata[d] = '0; k_err[d] = 1'b0;
      end else if (!busy[d]) begin
        check($sformatf("d%0d_idle_req_ready", d), {31'b0, req_ready[d]}, 32'd1);
        check($sformatf("d%0d_idle_resp_valid", d), {31'b0, resp_valid[d]}, 32'd0);
        if (out_known[d]) begin
          check($sformatf("d%0d_idle_rdata", d), resp_rdata[d], k_rdata[d]);
          check($sformatf("d%0d_idle_err", d), {31'b0, resp_err[d]}, {31'b0, k_err[d]});
        end
        if (req_valid[d]) begin
          busy[d]      = 1;
          resp_at[d]   = cyc + lat_of(d) + 1;
          committed[d] = 0;
          out_known[d] = 0;
          p_write[d]   = req_write[d];
          p_addr[d]    = req_addr[d];
          p_wdata[d]   = req_wdata[d];
          p_be[d]      = req_be[d];
        end
      end else begin
        check($sformatf("d%0d_busy_req_ready", d), {31'b0, req_ready[d]}, 32'd0);
        if (cyc < resp_at[d]) begin
          check($sformatf("d%0d_wait_resp_valid", d), {31'b0, resp_valid[d]}, 32'd0);
        end else begin
          if (!committed[d]) begin
            committed[d] = 1;
            if (p_addr[d] >= 32'(DEPTH)) begin
              k_err[d] = 1'b1; k_rdata[d] = '0;
            end else if (p_write[d]) begin
              for (int b = 0; b < 4; b++)
                if (p_be[d][b]) m_mem[d][p_addr[d][6:0]][8*b +: 8] = p_wdata[d][8*b +: 8];
              k_err[d] = 1'b0; k_rdata[d] = '0;
            end else begin
              k_err[d] = 1'b0; k_rdata[d] = m_mem[d][p_addr[d][6:0]];
            end
          end
          check($sformatf("d%0d_resp_valid", d), {31'b0, resp_valid[d]}, 32'd1);
          check($sformatf("d%0d_resp_rdata", d), resp_rdata[d], k_rdata[d]);
          check($sformatf("d%0d_resp_err", d), {31'b0, resp_err[d]}, {31'b0, k_err[d]});
          if (resp_ready[d]) busy[d] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // One full transaction; optionally stalls the response for `hold` cycles
  // while presenting a bogus request that must be ignored.
  task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
    longint t_acc, t_rsp;
    bit got;
    rdata = '0; err = 1'b0; lat = -1; t_acc = 0; t_rsp = 0;
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be; resp_ready[d] = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin got = 1; t_acc = cyc; end
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0; req_addr[d] = $urandom; req_wdata[d] = $urandom;
    if (!got) begin check("accept_timeout", 32'd0, 32'd1); return; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid[d]) begin got = 1; t_rsp = cyc; end
      else begin @(posedge clk); #1; end
    end
    if (!got) begin check("resp_timeout", 32'd0, 32'd1); return; end
    lat = int'(t_rsp - t_acc);
    @(posedge clk); #1;
    if (hold > 0) begin
      req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 32'd5;
      req_wdata[d] = 32'hFFFF_FFFF; req_be[d] = 4'hF;
      repeat (hold) begin @(posedge clk); #1; end
      req_valid[d] = 1'b0;
    end
    rdata = resp_rdata[d]; err = resp_err[d]; resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    @(negedge clk);
    check("ready_after_retire", {31'b0, req_ready[d]}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Back-to-back store/load with resp_ready held high; checks acceptance spacing.
  task automatic stream(input int d);
    int     p;
    int     n;
    longint last;
    bit     acc;
    bit     wr;
    p = lat_of(d) + 2; n = 0; last = -1; wr = 1;
    resp_ready[d] = 1'b1; req_valid[d] = 1'b1; req_write[d] = wr;
    req_addr[d] = $urandom_range(0, DEPTH-1); req_wdata[d] = $urandom; req_be[d] = 4'hF;
    for (int i = 0; i < 6*p; i++) begin
      @(negedge clk);
      acc = req_ready[d];
      if (acc) begin
        if (last >= 0) check("stream_spacing", 32'(cyc - last), 32'(p));
        last = cyc; n++;
      end
      @(posedge clk); #1;
      if (acc) begin
        wr = !wr; req_write[d] = wr; req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
      end
    end
    req_valid[d] = 1'b0;
    repeat (p + 2) @(posedge clk);
    #1 resp_ready[d] = 1'b0;
    check("stream_count", 32'(n), 32'd6);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Fill both memories with known contents.
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a++)
        do_req(d, 1'b1, 32'(a), (a == 7) ? 32'h0 : (a == 127) ? 32'hCAFE_F00D : $urandom,
               4'hF, 0, rd, er, lt);

    // Full-word store then load, with latency pinned.
    do_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lt);
    check("st5_latency", 32'(lt), 32'd3);
    check("st5_rdata", rd, 32'd0);
    check("st5_err", {31'b0, er}, 32'd0);
    do_req(0, 1'b0, 32'd5, 32'h0, 4'h0, 0, rd, er, lt);
    check("ld5_latency", 32'(lt), 32'd3);
    check("ld5_rdata", rd, 32'hDEAD_BEEF);
    check("ld5_err", {31'b0, er}, 32'd0);

    // Partial-byte store merges with existing word.
    do_req(0, 1'b1, 32'd5, 32'h0000_1234, 4'h3, 0, rd, er, lt);
    do_req(0, 1'b0, 32'd5, 32'h0, 4'h0, 0, rd, er, lt);
    check("ld5_merged", rd, 32'hDEAD_1234);

    // Out-of-range accesses, including high address bits (no wrap).
    do_req(0, 1'b0, 32'd128, 32'h0, 4'h0, 0, rd, er, lt);
    check("ld128_err", {31'b0, er}, 32'd1);
    check("ld128_rdata", rd, 32'd0);
    do_req(0, 1'b1, 32'd200, 32'h5555_AAAA, 4'hF, 0, rd, er, lt);
    check("st200_err", {31'b0, er}, 32'd1);
    do_req(0, 1'b0, 32'd127, 32'h0, 4'h0, 0, rd, er, lt);
    check("ld127_unchanged", rd, 32'hCAFE_F00D);
    do_req(0, 1'b1, 32'h8000_0005, 32'h0BAD_0BAD, 4'hF, 0, rd, er, lt);
    check("st_hi_err", {31'b0, er}, 32'd1);

    // be=0 store is a no-op that still responds.
    do_req(0, 1'b1, 32'd5, 32'h9999_9999, 4'h0, 0, rd, er, lt);
    check("st_be0_err", {31'b0, er}, 32'd0);

    // Stalled response with an ignored second request (would clobber addr 5).
    do_req(0, 1'b0, 32'd5, 32'h0, 4'h0, 5, rd, er, lt);
    check("hold_rdata", rd, 32'hDEAD_1234);
    do_req(0, 1'b0, 32'd5, 32'h0, 4'h0, 0, rd, er, lt);
    check("after_hold_rdata", rd, 32'hDEAD_1234);

    // Reset in WAIT of a store to addr 7: store must be dropped.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'd7;
    req_wdata[0] = 32'h1111_1111; req_be[0] = 4'hF;
    begin : rst_accept
      bit got;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = req_ready[0];
        @(posedge clk); #1;
      end
      if (!got) check("rst_accept_timeout", 32'd0, 32'd1);
    end
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'b0, req_ready[0]}, 32'd0);
    check("rst_mid_valid", {31'b0, resp_valid[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rst_no_resp", {31'b0, resp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'd7, 32'h0, 4'h0, 0, rd, er, lt);
    check("ld7_after_rst", rd, 32'h0);

    // Throughput on both builds.
    stream(0);
    stream(1);

    // LAT=0 build: one-cycle response.
    do_req(1, 1'b1, 32'd9, 32'h0123_4567, 4'hF, 0, rd, er, lt);
    check("lat0_st_latency", 32'(lt), 32'd1);
    do_req(1, 1'b0, 32'd9, 32'h0, 4'h0, 0, rd, er, lt);
    check("lat0_ld_latency", 32'(lt), 32'd1);
    check("lat0_ld_rdata", rd, 32'h0123_4567);

    // Random traffic; the compare process checks every response.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH));
        do_req(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
               $urandom_range(0, 3), rd, er, lt);
        check("rand_latency", 32'(lt), 32'(lat_of(d) + 1));
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
